// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall/flush controller.
//   ctrl_state_e : controller FSM states
//   pipe_ctrl_t  : bundle of pipeline-register enables/flushes and PC select
//   FWD_*        : EX operand source encodings
//   fwd_select   : forwarding priority function (EX/MEM over MEM/WB, $0 never forwards)
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_e;

    localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
    localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;
    localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b01;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // Pipeline control bundle, MSB first.
    typedef struct packed {
        logic pc_en;
        logic pc_sel_target;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_NORMAL   = 8'b1010_1010;
    localparam pipe_ctrl_t CTRL_LOAD_USE = 8'b0000_1110;
    localparam pipe_ctrl_t CTRL_BRANCH   = 8'b1111_1110;
    localparam pipe_ctrl_t CTRL_FREEZE   = 8'b0000_0001;

    // Select the EX operand source for one source register.
    function automatic logic [FWD_W-1:0] fwd_select(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] mem_wr,
        input logic             mem_rw,
        input logic [REG_W-1:0] wb_wr,
        input logic             wb_rw
    );
        logic [FWD_W-1:0] sel;
        sel = FWD_RF;
        if (mem_rw && (mem_wr != REG_ZERO) && (mem_wr == src)) begin
            sel = FWD_EXMEM;
        end else if (wb_rw && (wb_wr != REG_ZERO) && (wb_wr == src)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Combinational EX operand forwarding selector.
//   ex_rs/ex_rt          : source registers of the instruction in EX
//   mem_write_reg/_write : destination of the instruction in MEM
//   wb_write_reg/_write  : destination of the instruction in WB
//   forward_a/forward_b  : operand A/B source (FWD_RF, FWD_EXMEM, FWD_MEMWB)
module forward_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] mem_write_reg,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] wb_write_reg,
    input  logic             wb_reg_write,
    output logic [FWD_W-1:0] forward_a,
    output logic [FWD_W-1:0] forward_b
);

    assign forward_a = fwd_select(ex_rs, mem_write_reg, mem_reg_write, wb_write_reg, wb_reg_write);
    assign forward_b = fwd_select(ex_rt, mem_write_reg, mem_reg_write, wb_write_reg, wb_reg_write);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, stall and flush controller for the 5-stage MIPS pipeline.
// Inputs : ID/EX/MEM/WB register fields, branch resolution, data-memory handshake.
// Outputs: PC and pipeline-register enables/flushes, EX forwarding selects
//          (combinational), halted and stall_cycles (registered).
// FSM: RUN -> MEM_WAIT on a stalled memory access; MEM_WAIT -> RUN on mem_ready,
//      or -> ERROR after TIMEOUT_CYCLES consecutive wait cycles; ERROR exits only on rst.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_write_reg,
    input  logic             ex_branch_taken,
    input  logic [REG_W-1:0] mem_write_reg,
    input  logic             mem_reg_write,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic [REG_W-1:0] wb_write_reg,
    input  logic             wb_reg_write,
    output logic             pc_en,
    output logic             pc_sel_target,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_flush,
    output logic [FWD_W-1:0] forward_a,
    output logic [FWD_W-1:0] forward_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned        WAIT_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0]  TIMEOUT_VAL = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;

    ctrl_state_e       state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next, wait_inc;
    logic              load_use;
    pipe_ctrl_t        run_ctrl, ctrl;

    forward_unit u_forward_unit (
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .mem_write_reg (mem_write_reg),
        .mem_reg_write (mem_reg_write),
        .wb_write_reg  (wb_write_reg),
        .wb_reg_write  (wb_reg_write),
        .forward_a     (forward_a),
        .forward_b     (forward_b)
    );

    // Load in EX feeding a source of the instruction in ID; $0 never stalls.
    assign load_use = ex_mem_read && (ex_write_reg != REG_ZERO) &&
                      ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));

    assign wait_inc = wait_cnt + WAIT_W'(1);

    // Controls when memory is not holding the pipe; branch squashes the wrong-path load-use.
    always_comb begin
        run_ctrl = CTRL_NORMAL;
        if (ex_branch_taken) begin
            run_ctrl = CTRL_BRANCH;
        end else if (load_use) begin
            run_ctrl = CTRL_LOAD_USE;
        end
    end

    // Next state, wait counter and pipeline controls.
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        ctrl       = run_ctrl;
        case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    ctrl       = CTRL_FREEZE;
                    wait_next  = WAIT_W'(1);
                    state_next = (TIMEOUT_CYCLES <= 1) ? ERROR : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_next = RUN;
                    wait_next  = '0;
                end else begin
                    ctrl      = CTRL_FREEZE;
                    wait_next = wait_inc;
                    if (wait_inc >= TIMEOUT_VAL) begin
                        state_next = ERROR;
                    end
                end
            end
            ERROR: begin
                ctrl = CTRL_FREEZE;
            end
            default: begin
                ctrl       = CTRL_FREEZE;
                state_next = ERROR;
            end
        endcase
    end

    // State, wait counter, halt flag and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            halted       <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            halted   <= (state_next == ERROR);
            if (!ctrl.pc_en && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

    assign pc_en         = ctrl.pc_en;
    assign pc_sel_target = ctrl.pc_sel_target;
    assign if_id_en      = ctrl.if_id_en;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_en      = ctrl.id_ex_en;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign ex_mem_en     = ctrl.ex_mem_en;
    assign mem_wb_flush  = ctrl.mem_wb_flush;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a table of single-cycle vectors
// from RUN, then hand-written multi-cycle sequences for waits, timeout and reset.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CW      = 4;

    // Expected control bundles {pc_en, pc_sel_target, if_id_en, if_id_flush,
    // id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}.
    localparam logic [7:0] E_NORM = 8'b1010_1010;
    localparam logic [7:0] E_LU   = 8'b0000_1110;
    localparam logic [7:0] E_BR   = 8'b1111_1110;
    localparam logic [7:0] E_FRZ  = 8'b0000_0001;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_write_reg, mem_write_reg, wb_write_reg;
    logic id_uses_rt, ex_mem_read, ex_branch_taken, mem_reg_write, mem_req, mem_ready, wb_reg_write;
    logic pc_en, pc_sel_target, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
    logic [1:0] forward_a, forward_b;
    logic halted;
    logic [CW-1:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
        .ex_write_reg(ex_write_reg), .ex_branch_taken(ex_branch_taken),
        .mem_write_reg(mem_write_reg), .mem_reg_write(mem_reg_write),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_write_reg(wb_write_reg), .wb_reg_write(wb_reg_write),
        .pc_en(pc_en), .pc_sel_target(pc_sel_target), .if_id_en(if_id_en),
        .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .mem_wb_flush(mem_wb_flush),
        .forward_a(forward_a), .forward_b(forward_b),
        .halted(halted), .stall_cycles(stall_cycles)
    );

    wire [7:0] act_ctrl = {pc_en, pc_sel_target, if_id_en, if_id_flush,
                           id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush};

    typedef struct {
        logic [4:0] id_rs, id_rt;
        logic       id_uses_rt;
        logic [4:0] ex_rs, ex_rt;
        logic       ex_mem_read;
        logic [4:0] ex_write_reg;
        logic       ex_branch_taken;
        logic [4:0] mem_write_reg;
        logic       mem_reg_write, mem_req, mem_ready;
        logic [4:0] wb_write_reg;
        logic       wb_reg_write;
        logic [7:0] exp_ctrl;
        logic [1:0] exp_fa, exp_fb;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    function automatic vec_t mk(
        input logic [4:0] irs, input logic [4:0] irt, input logic urt,
        input logic [4:0] ers, input logic [4:0] ert, input logic emr, input logic [4:0] ewr,
        input logic br, input logic [4:0] mwr, input logic mrw, input logic mrq, input logic mrdy,
        input logic [4:0] wwr, input logic wrw,
        input logic [7:0] ec, input logic [1:0] fa, input logic [1:0] fb);
        vec_t v;
        v.id_rs = irs; v.id_rt = irt; v.id_uses_rt = urt;
        v.ex_rs = ers; v.ex_rt = ert; v.ex_mem_read = emr; v.ex_write_reg = ewr;
        v.ex_branch_taken = br; v.mem_write_reg = mwr; v.mem_reg_write = mrw;
        v.mem_req = mrq; v.mem_ready = mrdy; v.wb_write_reg = wwr; v.wb_reg_write = wrw;
        v.exp_ctrl = ec; v.exp_fa = fa; v.exp_fb = fb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_rs = v.id_rs; id_rt = v.id_rt; id_uses_rt = v.id_uses_rt;
        ex_rs = v.ex_rs; ex_rt = v.ex_rt; ex_mem_read = v.ex_mem_read;
        ex_write_reg = v.ex_write_reg; ex_branch_taken = v.ex_branch_taken;
        mem_write_reg = v.mem_write_reg; mem_reg_write = v.mem_reg_write;
        mem_req = v.mem_req; mem_ready = v.mem_ready;
        wb_write_reg = v.wb_write_reg; wb_reg_write = v.wb_reg_write;
    endtask

    task automatic clear_inputs();
        drive(mk(0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0, E_NORM,2'b00,2'b00));
    endtask

    // Leaves the bench at a falling edge with rst low and the DUT in reset state.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        //                     irs irt u  ers ert emr ewr br mwr mrw mrq rdy wwr wrw  ctrl    fa     fb
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM, 2'b00, 2'b00);
        vecs[1]  = mk(2, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, E_LU,   2'b00, 2'b00);
        vecs[2]  = mk(3, 7, 1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, E_LU,   2'b00, 2'b00);
        vecs[3]  = mk(3, 7, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, E_NORM, 2'b00, 2'b00);
        vecs[4]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM, 2'b00, 2'b00);
        vecs[5]  = mk(2, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, E_NORM, 2'b00, 2'b00);
        vecs[6]  = mk(0, 0, 0, 5, 0, 0, 0, 0, 5, 1, 0, 0, 5, 1, E_NORM, 2'b10, 2'b00);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 5, 1, E_NORM, 2'b00, 2'b00);
        vecs[8]  = mk(0, 0, 0, 9, 9, 0, 0, 0, 0, 0, 0, 0, 9, 1, E_NORM, 2'b01, 2'b01);
        vecs[9]  = mk(0, 0, 0, 4, 0, 0, 0, 0, 4, 0, 0, 0, 4, 1, E_NORM, 2'b01, 2'b00);
        vecs[10] = mk(0, 0, 0, 6, 3, 0, 0, 0, 3, 1, 0, 0, 6, 1, E_NORM, 2'b01, 2'b10);
        vecs[11] = mk(2, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, E_BR,   2'b00, 2'b00);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, E_NORM, 2'b00, 2'b00);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, E_NORM, 2'b00, 2'b00);

        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_stall", 32'(stall_cycles), 32'd0);
        check("reset_ctrl", 32'(act_ctrl), 32'(E_NORM));

        // Single-cycle table from RUN.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("vec%0d_ctrl", i), 32'(act_ctrl), 32'(vecs[i].exp_ctrl));
            check($sformatf("vec%0d_fwd_a", i), 32'(forward_a), 32'(vecs[i].exp_fa));
            check($sformatf("vec%0d_fwd_b", i), 32'(forward_b), 32'(vecs[i].exp_fb));
        end

        // Load-use: one bubble, then normal flow; one stall cycle counted.
        do_reset();
        drive(vecs[1]);
        #1;
        check("lu_bubble", 32'(act_ctrl), 32'(E_LU));
        @(negedge clk);
        ex_mem_read = 1'b0;
        #1;
        check("lu_release", 32'(act_ctrl), 32'(E_NORM));
        check("lu_stall_cnt", 32'(stall_cycles), 32'd1);

        // Memory wait for 3 cycles, released on the 4th.
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            check($sformatf("mw_freeze%0d", k), 32'(act_ctrl), 32'(E_FRZ));
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        check("mw_release", 32'(act_ctrl), 32'(E_NORM));
        check("mw_stall_cnt", 32'(stall_cycles), 32'd3);
        @(negedge clk);
        mem_req = 1'b0; mem_ready = 1'b0;
        #1;
        check("mw_back_run", 32'(act_ctrl), 32'(E_NORM));
        check("mw_stall_hold", 32'(stall_cycles), 32'd3);

        // Timeout into ERROR, stall counter saturation, then reset recovery.
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("to_halted%0d", k), 32'(halted), (k == 4) ? 32'd1 : 32'd0);
            check($sformatf("to_stall%0d", k), 32'(stall_cycles), 32'(k));
        end
        mem_ready = 1'b1;
        #1;
        check("err_freeze", 32'(act_ctrl), 32'(E_FRZ));
        repeat (14) @(negedge clk);
        check("err_halted", 32'(halted), 32'd1);
        check("err_stall_sat", 32'(stall_cycles), 32'd15);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        #1;
        check("err_rst_ctrl", 32'(act_ctrl), 32'(E_NORM));
        check("err_rst_halted", 32'(halted), 32'd0);
        check("err_rst_stall", 32'(stall_cycles), 32'd0);

        // Branch during MEM_WAIT takes effect only on the release cycle.
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            #1;
            check($sformatf("bw_freeze%0d", k), 32'(act_ctrl), 32'(E_FRZ));
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        check("bw_release", 32'(act_ctrl), 32'(E_BR));
        @(negedge clk);
        ex_branch_taken = 1'b0; mem_req = 1'b0;
        #1;
        check("bw_stall_cnt", 32'(stall_cycles), 32'd2);

        // Reset in the middle of a wait returns to RUN despite mem_ready low.
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_req = 1'b0;
        #1;
        check("rst_wait_ctrl", 32'(act_ctrl), 32'(E_NORM));
        check("rst_wait_stall", 32'(stall_cycles), 32'd0);
        check("rst_wait_halted", 32'(halted), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard, stall and flush controller for the 5-stage MIPS pipeline. It watches the ID, EX, MEM and WB stage register fields and generates enable, flush and forwarding controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also sequences data-memory wait states and flags memory timeouts.

Parameters:
TIMEOUT_CYCLES, 64, maximum consecutive MEM wait cycles before the block declares an error
CNT_W, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  instruction in ID reads rt as a source
ex_rs  in  5  rs of the instruction in EX
ex_rt  in  5  rt of the instruction in EX
ex_mem_read  in  1  instruction in EX is a load
ex_write_reg  in  5  destination register of the instruction in EX
ex_branch_taken  in  1  branch/jump resolved taken in EX
mem_write_reg  in  5  destination register of the instruction in MEM
mem_reg_write  in  1  instruction in MEM writes the register file (DataC)
mem_req  in  1  instruction in MEM accesses data memory
mem_ready  in  1  data memory completes access this cycle
wb_write_reg  in  5  destination register of the instruction in WB
wb_reg_write  in  1  instruction in WB writes the register file
pc_en  out  1  PC update enable
pc_sel_target  out  1  load the branch target into the PC
if_id_en  out  1  IF/ID register enable
if_id_flush  out  1  zero the IF/ID register
id_ex_en  out  1  ID/EX register enable
id_ex_flush  out  1  zero the ID/EX control bits (insert a bubble)
ex_mem_en  out  1  EX/MEM register enable
mem_wb_flush  out  1  force DataC=0 into MEM/WB
forward_a  out  2  EX operand A source: 00 = register file, 10 = EX/MEM, 01 = MEM/WB
forward_b  out  2  EX operand B source, same encoding as forward_a
halted  out  1  controller is in the ERROR state
stall_cycles  out  CNT_W  count of cycles in which pc_en = 0

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR. Next-state logic is registered; all outputs are combinational from state and inputs, except halted and stall_cycles, which are registered.
- Reset: state = RUN, wait counter = 0, stall_cycles = 0, halted = 0.
- Default outputs in RUN with no hazard:
  - all enables = 1
  - all flushes = 0
  - pc_sel_target = 0
  - forward_a = forward_b = 00
- Forwarding (every state; combinational):
  - forward_a = 10 if mem_reg_write and mem_write_reg != 0 and mem_write_reg == ex_rs.
  - Otherwise forward_a = 01 if wb_reg_write and wb_write_reg != 0 and wb_write_reg == ex_rs.
  - Otherwise forward_a = 00.
  - forward_b uses the same rules with ex_rt. EX/MEM has priority over MEM/WB.
- Hazard priority, highest first: memory wait, branch taken, load-use.
- Memory wait (RUN, mem_req = 1 and mem_ready = 0):
  - Same cycle: pc_en = if_id_en = id_ex_en = ex_mem_en = 0 and mem_wb_flush = 1.
  - Next state = MEM_WAIT. The wait counter loads 1.
- MEM_WAIT:
  - Same freeze outputs as above.
  - If mem_ready = 1: release the freeze that cycle (normal RUN outputs, evaluated with the other hazards), go to RUN, clear the counter.
  - Else the counter increments. When the counter reaches TIMEOUT_CYCLES: go to ERROR.
- ERROR:
  - All enables = 0, mem_wb_flush = 1, halted = 1.
  - The state is left only by rst.
- Branch taken (RUN, no memory wait):
  - pc_sel_target = 1, if_id_flush = 1, id_ex_flush = 1, pc_en = 1.
  - Any simultaneous load-use condition is ignored, because the instruction in ID is on the wrong path.
  - A branch taken while frozen takes effect on the release cycle, since EX is held stable.
- Load-use (RUN):
  - Condition: ex_mem_read and ex_write_reg != 0 and (ex_write_reg == id_rs or (id_uses_rt and ex_write_reg == id_rt)).
  - Response: pc_en = 0, if_id_en = 0, id_ex_flush = 1.
  - Exactly one bubble per load. The condition clears naturally on the next cycle.
- Register $0 never triggers forwarding or a stall.
- stall_cycles increments in every cycle where pc_en = 0, including ERROR. It saturates at all-ones and does not wrap.
- rst asserted mid-wait or in ERROR returns the block to the reset values on the next edge, regardless of mem_ready.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - FSM state enum {RUN, MEM_WAIT, ERROR}
  - forwarding encodings FWD_RF = 2'b00, FWD_EXMEM = 2'b10, FWD_MEMWB = 2'b01
  - constant REG_ZERO = 5'd0
- One sub-module, forward_unit: purely combinational, produces forward_a/forward_b. Shared with a future branch-in-ID comparator.

Test Plan:
1. lw $2 in EX (ex_mem_read = 1, ex_write_reg = 2), ID has id_rs = 2 -> one cycle of pc_en = 0, if_id_en = 0, id_ex_flush = 1; the next cycle returns to all enables = 1; stall_cycles = 1.
2. mem_reg_write = 1, mem_write_reg = 5; wb_reg_write = 1, wb_write_reg = 5; ex_rs = 5, ex_rt = 0 -> forward_a = 10, forward_b = 00. Same case with ex_rs = 0 -> forward_a = 00.
3. ex_branch_taken = 1 together with a load-use condition -> pc_sel_target = 1, if_id_flush = 1, id_ex_flush = 1, pc_en = 1; no stall.
4. mem_req = 1, mem_ready low for 3 cycles then high -> 3 frozen cycles with mem_wb_flush = 1, released on the 4th cycle; stall_cycles = 3.
5. TIMEOUT_CYCLES = 4, mem_ready held low -> after 4 wait cycles halted = 1, all enables stay 0; rst for one cycle -> RUN, halted = 0, stall_cycles = 0.
6. Branch asserted during MEM_WAIT -> no pc_sel_target while frozen; pc_sel_target = 1 on the mem_ready release cycle.
